// File: rtl/muladd_issue_queue.sv
// In-order issue queue holding complete (src1, src2, src3, tag) triples for the MULADD controller.
// Optional macro MULADD_BYPASS_EN lets a triple offered to an empty queue issue in the same cycle.
module muladd_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_src1,
    input  logic [31:0]              enq_src2,
    input  logic [31:0]              enq_src3,
    input  logic [TAG_W-1:0]         enq_tag,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [31:0]              iss_src1,
    output logic [31:0]              iss_src2,
    output logic [31:0]              iss_src3,
    output logic [TAG_W-1:0]         iss_tag,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      src3;
        logic [31:0]      src2;
        logic [31:0]      src1;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    entry_t enq_entry;
    entry_t head_entry;
    logic   stored_valid;
    logic   bypass;
    logic   do_write;
    logic   do_read;

    assign enq_entry    = '{tag: enq_tag, src3: enq_src3, src2: enq_src2, src1: enq_src1};
    assign stored_valid = (count_q != '0);
    // Registered-only ready: never looks at iss_ready, hence the one-cycle bubble when full.
    assign enq_ready    = (count_q != CNT_W'(DEPTH));

`ifdef MULADD_BYPASS_EN
    assign bypass     = !stored_valid && enq_valid && !flush;
    assign head_entry = bypass ? enq_entry : mem_q[rd_ptr_q];
`else
    assign bypass     = 1'b0;
    assign head_entry = mem_q[rd_ptr_q];
`endif

    assign iss_valid = stored_valid || bypass;
    assign iss_src1  = head_entry.src1;
    assign iss_src2  = head_entry.src2;
    assign iss_src3  = head_entry.src3;
    assign iss_tag   = head_entry.tag;
    assign occupancy = count_q;

    // A bypassed triple taken downstream is never written.
    assign do_write = enq_valid && enq_ready && !flush && !(bypass && iss_ready);
    assign do_read  = stored_valid && iss_ready && !flush;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_read)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_write, do_read})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= enq_entry;
    end

endmodule

// File: tb/tb_muladd_issue_queue.sv
// Self-checking bench for muladd_issue_queue: directed scenarios plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_muladd_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int VW    = 2 + CNT_W + TAG_W + 96;
`ifdef MULADD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      s3;
        logic [31:0]      s2;
        logic [31:0]      s1;
    } trip_t;

    logic clk = 1'b0;
    logic rst_n, flush, enq_valid, enq_ready, iss_valid, iss_ready;
    logic [31:0] enq_src1, enq_src2, enq_src3, iss_src1, iss_src2, iss_src3;
    logic [TAG_W-1:0] enq_tag, iss_tag;
    logic [CNT_W-1:0] occupancy;

    trip_t            mq[$];
    logic [TAG_W-1:0] handed[$];
    int checks   = 0;
    int failures = 0;

    muladd_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_src1(enq_src1), .enq_src2(enq_src2), .enq_src3(enq_src3), .enq_tag(enq_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_src3(iss_src3), .iss_tag(iss_tag),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] obs_vec();
        logic [TAG_W+95:0] p;
        p = iss_valid ? {iss_tag, iss_src3, iss_src2, iss_src1} : '0;
        return {iss_valid, enq_ready, occupancy, p};
    endfunction

    // Expected outputs from the queue contents and the current inputs.
    function automatic logic [VW-1:0] exp_vec();
        trip_t h;
        logic  ev;
        ev = (mq.size() != 0) || (BYP && enq_valid && !flush);
        h  = (mq.size() != 0) ? mq[0] : trip_t'({enq_tag, enq_src3, enq_src2, enq_src1});
        return {ev, (mq.size() < DEPTH) ? 1'b1 : 1'b0, CNT_W'(mq.size()), ev ? h : trip_t'('0)};
    endfunction

    task automatic drive(input logic v, input int tag, input logic rdy, input logic fl);
        enq_valid = v;
        enq_tag   = TAG_W'(tag);
        enq_src1  = $urandom;
        enq_src2  = $urandom;
        enq_src3  = $urandom;
        iss_ready = rdy;
        flush     = fl;
        #1;
    endtask

    // Advance one clock, logging handed-over tags and updating the model.
    task automatic tick();
        trip_t e;
        int    n;
        e = '{enq_tag, enq_src3, enq_src2, enq_src1};
        n = mq.size();
        if (rst_n && iss_valid === 1'b1 && iss_ready) handed.push_back(iss_tag);
        if (!rst_n || flush) begin
            mq.delete();
        end else if (!(BYP && n == 0 && enq_valid && iss_ready)) begin
            if (n != 0 && iss_ready) void'(mq.pop_front());
            if (enq_valid && n < DEPTH) mq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 3, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if ({iss_valid, enq_ready, occupancy} !== {1'b0, 1'b1, CNT_W'(0)}) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {iss_valid, enq_ready, occupancy}, {1'b0, 1'b1, CNT_W'(0)});
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_vec got=%h exp=%h", obs_vec(), exp_vec());
        end
        handed.delete();
    endtask

    task automatic test_single();
        handed.delete();
        drive(1'b1, 2, 1'b1, 1'b0);
        enq_src1 = 32'h3;
        enq_src2 = 32'h5;
        enq_src3 = 32'h7;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single_c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            tick();
            drive(1'b0, 0, 1'b1, 1'b0);
        end
        checks++;
        if (handed.size() != 1 || handed[0] !== TAG_W'(2)) begin
            failures++;
            $display("FAIL single_handed got_count=%0d exp_count=1 (tag 2)", handed.size());
        end
    endtask

    task automatic test_fill();
        handed.delete();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, i, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL fill_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        drive(1'b1, 9, 1'b0, 1'b0);
        checks++;
        if ({enq_ready, occupancy} !== {1'b0, CNT_W'(DEPTH)}) begin
            failures++;
            $display("FAIL fill_full got=%b exp=%b", {enq_ready, occupancy}, {1'b0, CNT_W'(DEPTH)});
        end
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 0, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL drain_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        checks++;
        if (handed.size() != DEPTH) begin
            failures++;
            $display("FAIL fill_count got=%0d exp=%0d", handed.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (handed[i] !== TAG_W'(i)) begin
                    failures++;
                    $display("FAIL fill_order_%0d got=%0d exp=%0d", i, handed[i], i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        handed.delete();
        drive(1'b1, 0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i + 2, 1'b1, 1'b0);
            checks++;
            if (occupancy !== CNT_W'(2) || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 0, 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= handed.size() || handed[i] !== TAG_W'(i)) begin
                failures++;
                $display("FAIL b2b_order_%0d got_count=%0d exp_tag=%0d", i, handed.size(), i);
            end
        end
    endtask

    task automatic test_backpressure();
        trip_t held;
        handed.delete();
        drive(1'b1, 5, 1'b0, 1'b0);
        tick();
        held = mq[0];
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 1'b0, 1'b0);
            checks++;
            if ({iss_valid, iss_tag, iss_src3, iss_src2, iss_src1} !== {1'b1, held}) begin
                failures++;
                $display("FAIL hold_%0d got=%h exp=%h", i, {iss_valid, iss_tag, iss_src3, iss_src2, iss_src1}, {1'b1, held});
            end
            tick();
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (handed.size() != 1 || handed[0] !== TAG_W'(5) || iss_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_once got_count=%0d valid=%b exp_count=1 valid=0", handed.size(), iss_valid);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10 + i, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 15, 1'b0, 1'b1);
        checks++;
        if (occupancy !== CNT_W'(3) || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL flush_pre got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if ({iss_valid, occupancy} !== {1'b0, CNT_W'(0)}) begin
            failures++;
            $display("FAIL flush_post got=%b exp=%b", {iss_valid, occupancy}, {1'b0, CNT_W'(0)});
        end
        handed.delete();
        drive(1'b1, 6, 1'b1, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0);
        tick();
        checks++;
        if (handed.size() != 1 || handed[0] !== TAG_W'(6)) begin
            failures++;
            $display("FAIL flush_after got_count=%0d exp_count=1 (tag 6)", handed.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, i, 1'b0, 1'b0);
            tick();
        end
        rst_n = 1'b0;
        drive(1'b1, 7, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if ({iss_valid, enq_ready, occupancy} !== {1'b0, 1'b1, CNT_W'(0)}) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=%b", {iss_valid, enq_ready, occupancy}, {1'b0, 1'b1, CNT_W'(0)});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        iss_ready = 1'b0;
        enq_src1  = '0;
        enq_src2  = '0;
        enq_src3  = '0;
        enq_tag   = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muladd_issue_queue.md
# muladd_issue_queue

Buffers complete operand triples (source 1, source 2, source 3) for the fused multiply-add controller and issues them in order. Sits downstream of the source-value routing stage: that stage steers the MULADD copy of each operand here, and the queue presents one full triple at a time to the MULADD execution controller over a valid/ready handshake. It decouples operand delivery from multiplier-adder back-pressure.

## Interface
- DEPTH, 4: number of queue entries; power of two, 2..16
- TAG_W, 4: width of the instruction tag carried with each triple
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  discard all queued entries (synchronous)
- enq_valid  input  1  upstream offers a triple this cycle
- enq_ready  output  1  queue can accept a triple this cycle
- enq_src1  input  32  source 1 value
- enq_src2  input  32  source 2 value
- enq_src3  input  32  source 3 value (MULADD addend)
- enq_tag  input  TAG_W  instruction tag
- iss_valid  output  1  head triple is presented
- iss_ready  input  1  MULADD controller accepts head this cycle
- iss_src1, iss_src2, iss_src3  output  32 each  head operand values
- iss_tag  output  TAG_W  head tag
- occupancy  output  $clog2(DEPTH)+1  number of stored entries

## Operation
- Circular buffer, DEPTH entries; write pointer, read pointer, count register.
- Enqueue fires when enq_valid && enq_ready; dequeue fires when iss_valid && iss_ready.
- enq_ready = (count != DEPTH); depends only on registered state, never on iss_ready.
- iss_valid = (count != 0) (plus bypass case, see Configuration); iss_* driven from entry at read pointer (show-ahead).
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; wrap from DEPTH-1 to 0 must not disturb count.
- Strict FIFO order; a triple is never reordered, duplicated or split.
- flush: count, read and write pointers cleared next edge; any enqueue in the same cycle is dropped; any dequeue in the same cycle still counts as handed over (downstream sampled it) but has no further effect.
- Priority per edge: rst_n low > flush > enqueue/dequeue.
- Holding rule: while iss_valid && !iss_ready, iss_* stay stable.
- Storage contents need not be reset; only control state is.

## Timing
- Reset (rst_n low at edge): count=0, pointers=0; outputs then iss_valid=0, enq_ready=1, occupancy=0; iss_* don't-care but must not be X-propagated into valid.
- Reset mid-operation: all entries lost, same state as power-on reset next cycle.
- Enqueue-to-issue latency (bypass absent): triple enqueued at edge N is visible on iss_* with iss_valid=1 after edge N when queue was empty.
- Full: enq_ready=0 the cycle after count reaches DEPTH; a dequeue that cycle re-asserts enq_ready after that edge (one-cycle bubble on full by design).
- Empty: iss_valid=0 the cycle after last dequeue unless an enqueue happened that same edge.
- occupancy equals count register, updated at each edge.

## Configuration
- MULADD_BYPASS_EN defined: when count==0 and enq_valid=1, iss_valid=1 and iss_* = enq_* combinationally in the same cycle; if iss_ready=1 the triple is consumed and not written (count stays 0); if iss_ready=0 it is written normally. flush in that cycle suppresses bypass (iss_valid=0).
- MULADD_BYPASS_EN undefined: no combinational path from enq_* to iss_*; minimum latency one cycle as in Timing.

## Test plan
- Reset then single triple (src1=0x3, src2=0x5, src3=0x7, tag=2), iss_ready=1 -> iss_valid one cycle later with those values, occupancy 1 then 0, without bypass; with bypass issued same cycle, occupancy stays 0.
- Fill with DEPTH=4 triples tags 0..3, iss_ready=0 -> enq_ready=0, occupancy=4; fifth offer ignored; drain -> tags 0,1,2,3 in order.
- Continuous enq/deq both high for 10 cycles from count=2 -> occupancy constant 2, pointers wrap, output order preserved (tags 0..9).
- Back-pressure: iss_ready=0 for 3 cycles with head tag 5 -> iss_* stable, then accepted exactly once.
- flush with count=3 and enq_valid=1 same cycle -> next cycle occupancy=0, iss_valid=0, enqueued triple absent.
- rst_n low for one cycle while count=2 and mid-handshake -> iss_valid=0, enq_ready=1, occupancy=0 next cycle; subsequent traffic correct.
